// File: rtl/data_mem_sized_pkg.sv
// Shared definitions for the sized data memory: access-size codes, FSM states,
// byte-lane enable and load-extension helpers (big-endian lane numbering).
package data_mem_sized_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Lane 3 is bits [31:24], i.e. the byte at offset 0 (big-endian).
  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] ofs);
    logic [3:0] en;
    en = 4'b0000;
    case (sz)
      SZ_BYTE: en = 4'b1000 >> ofs;
      SZ_HALF: en = ofs[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] ofs, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ofs)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = ofs[1] ? word[15:0] : word[31:16];
    case (sz)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_mem_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_sized_bank.sv
// Word-organised storage with per-byte-lane write enables and a registered read port.
// One access per cycle; read data updates only when re_i is set and holds otherwise.
module data_mem_bank #(
  parameter int unsigned WORDS_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic [WORDS_LOG2-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**WORDS_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_sized.sv
// Byte/half/word big-endian data memory with optional post-reset clear sweep.
// Response READ_LATENCY edges after acceptance; ready only in RUN, never backpressured by responses.
module data_mem_sized
  import data_mem_sized_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  data_mem_sized_if.slave bus_if
);

  localparam int unsigned WL2 = ADDR_WIDTH - 2;
  localparam logic [WL2-1:0] LAST_WORD = '1;

  state_e         state_q, state_d;
  logic [WL2-1:0] clr_q, clr_d;

  logic           accept;
  logic           req_err;
  logic [3:0]     lanes;
  logic [WL2-1:0] bank_addr;
  logic [3:0]     bank_we;
  logic [31:0]    bank_wdata;
  logic           bank_re;
  logic [31:0]    bank_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      RESET: begin
        clr_d   = '0;
        state_d = CLEAR_ON_RESET ? CLEAR : RUN;
      end
      CLEAR: begin
        if (clr_q == LAST_WORD) state_d = RUN;
        else                    clr_d   = clr_q + WL2'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = RESET;
    endcase
  end

  assign bus_if.req_ready = (state_q == RUN);
  assign accept           = bus_if.req_valid && bus_if.req_ready;

  assign req_err = (bus_if.req_size == SZ_RSVD)
                || ((bus_if.req_size == SZ_HALF) && bus_if.req_addr[0])
                || ((bus_if.req_size == SZ_WORD) && (bus_if.req_addr[1:0] != 2'b00))
                || ((bus_if.req_addr >> ADDR_WIDTH) != 32'd0);

  assign lanes = lane_en(bus_if.req_size, bus_if.req_addr[1:0]);

  // Replicating the right-justified store data lets the lane enables pick the slot.
  always_comb begin
    bank_addr  = bus_if.req_addr[ADDR_WIDTH-1:2];
    bank_we    = 4'b0000;
    bank_re    = 1'b0;
    case (bus_if.req_size)
      SZ_BYTE: bank_wdata = {4{bus_if.req_wdata[7:0]}};
      SZ_HALF: bank_wdata = {2{bus_if.req_wdata[15:0]}};
      default: bank_wdata = bus_if.req_wdata;
    endcase
    if (state_q == CLEAR) begin
      bank_addr  = clr_q;
      bank_we    = 4'b1111;
      bank_wdata = '0;
    end else if (accept && !req_err) begin
      if (bus_if.req_write) bank_we = lanes;
      else                  bank_re = 1'b1;
    end
  end

  data_mem_bank #(.WORDS_LOG2(WL2)) u_bank (
    .clk_i   (clk_i),
    .addr_i  (bank_addr),
    .we_i    (bank_we),
    .wdata_i (bank_wdata),
    .re_i    (bank_re),
    .rdata_o (bank_rdata)
  );

  // First response stage sits alongside the bank read register; zero_q masks stores/errors.
  logic        s1_vld_q, s1_err_q, s1_zero_q, s1_uns_q;
  logic [1:0]  s1_size_q, s1_off_q;
  logic [31:0] s1_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_zero_q <= 1'b1;
      s1_uns_q  <= 1'b0;
      s1_size_q <= SZ_WORD;
      s1_off_q  <= 2'b00;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_err_q  <= req_err;
        s1_zero_q <= req_err || bus_if.req_write;
        s1_uns_q  <= bus_if.req_unsigned;
        s1_size_q <= bus_if.req_size;
        s1_off_q  <= bus_if.req_addr[1:0];
      end
    end
  end

  assign s1_rdata = s1_zero_q ? 32'd0 : load_extend(bank_rdata, s1_size_q, s1_off_q, s1_uns_q);

  generate
    if (READ_LATENCY <= 1) begin : g_direct
      assign bus_if.rsp_valid = s1_vld_q;
      assign bus_if.rsp_rdata = s1_rdata;
      assign bus_if.rsp_error = s1_err_q;
    end else begin : g_pipe
      localparam int unsigned EXTRA = READ_LATENCY - 1;
      logic [EXTRA-1:0] vld_q;
      logic [EXTRA-1:0] err_q;
      logic [31:0]      dat_q [EXTRA];

      // Stages load only behind a valid, so the last stage holds between responses.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_q <= '0;
          err_q <= '0;
          for (int i = 0; i < EXTRA; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= s1_vld_q;
          if (s1_vld_q) begin
            dat_q[0] <= s1_rdata;
            err_q[0] <= s1_err_q;
          end
          for (int i = 1; i < EXTRA; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
              dat_q[i] <= dat_q[i-1];
              err_q[i] <= err_q[i-1];
            end
          end
        end
      end

      assign bus_if.rsp_valid = vld_q[EXTRA-1];
      assign bus_if.rsp_rdata = dat_q[EXTRA-1];
      assign bus_if.rsp_error = err_q[EXTRA-1];
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: two instances (latency 1 and 3) driven with identical requests.
module tb_data_mem_sized;
  import data_mem_sized_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_sized_if ifa ();
  data_mem_sized_if ifb ();

  data_mem_sized #(.ADDR_WIDTH(10), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus_if (ifa)
  );
  data_mem_sized #(.ADDR_WIDTH(10), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus_if (ifb)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t post[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.w = w; v.sz = sz; v.u = u; v.a = a; v.d = d; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [31:0] pat(input int j);
    return 32'hA5000000 | (j * 32'h00010001);
  endfunction

  task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    ifa.req_valid = v; ifa.req_write = w; ifa.req_size = sz;
    ifa.req_unsigned = u; ifa.req_addr = a; ifa.req_wdata = d;
    ifb.req_valid = v; ifb.req_write = w; ifb.req_size = sz;
    ifb.req_unsigned = u; ifb.req_addr = a; ifb.req_wdata = d;
  endtask

  // One request, then A is checked one edge later and B three edges later.
  task automatic xact(input string tag, input int idx, input vec_t v);
    drive(1'b1, v.w, v.sz, v.u, v.a, v.d);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
    check32($sformatf("%s%0d a.valid", tag, idx), ifa.rsp_valid, 1);
    check32($sformatf("%s%0d a.rdata", tag, idx), ifa.rsp_rdata, v.exp_rd);
    check32($sformatf("%s%0d a.error", tag, idx), ifa.rsp_error, v.exp_err);
    @(posedge clk); #1;
    check32($sformatf("%s%0d a.pulse_end", tag, idx), ifa.rsp_valid, 0);
    check32($sformatf("%s%0d b.early", tag, idx), ifb.rsp_valid, 0);
    @(posedge clk); #1;
    check32($sformatf("%s%0d b.valid", tag, idx), ifb.rsp_valid, 1);
    check32($sformatf("%s%0d b.rdata", tag, idx), ifb.rsp_rdata, v.exp_rd);
    check32($sformatf("%s%0d b.error", tag, idx), ifb.rsp_error, v.exp_err);
  endtask

  // Called right after rst drops; the first edge is RESET->CLEAR, then 256 clear edges.
  task automatic wait_ready(input string tag);
    int na, nb;
    na = 0; nb = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      if (na == 0 && ifa.req_ready) na = n;
      if (nb == 0 && ifb.req_ready) nb = n;
      if (na != 0 && nb != 0) break;
    end
    check32({tag, " a.edges_to_ready"}, na, 257);
    check32({tag, " b.edges_to_ready"}, nb, 257);
  endtask

  task automatic chk_stream(input string tag, input int i, input int lag, input logic vld,
                            input logic [31:0] rd, input logic er, inout int pulses);
    int r;
    logic expv;
    r = i - lag;
    expv = (r >= 0) && (r < 16);
    if (vld) pulses++;
    check32($sformatf("stream %s e%0d valid", tag, i), vld, expv);
    if (expv) begin
      check32($sformatf("stream %s r%0d rdata", tag, r), rd, (r < 8) ? 32'd0 : pat(15 - r));
      check32($sformatf("stream %s r%0d error", tag, r), er, 0);
    end
  endtask

  initial begin
    int pa, pb, nb;

    vecs.push_back(mk(0, SZ_WORD, 0, 32'h3FC, 0, 32'h00000000, 0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h010, 32'h11223344, 0, 0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h010, 0, 32'h00000011, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h012, 0, 32'h00003344, 0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h013, 32'h123456AA, 0, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h010, 0, 32'h112233AA, 0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h020, 32'h80FF7F01, 0, 0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h021, 0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h021, 0, 32'h000000FF, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h020, 0, 32'hFFFF80FF, 0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h020, 0, 32'h000080FF, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h021, 0, 32'h00000000, 1));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h022, 32'h55555555, 0, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h020, 0, 32'h80FF7F01, 0));
    vecs.push_back(mk(0, SZ_RSVD, 0, 32'h020, 0, 32'h00000000, 1));
    vecs.push_back(mk(1, SZ_RSVD, 0, 32'h020, 32'h00000000, 0, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h400, 0, 32'h00000000, 1));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h400, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h000, 0, 32'h00000000, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h020, 0, 32'h80FF7F01, 0));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h022, 32'hFFFFBEEF, 0, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h020, 0, 32'h80FFBEEF, 0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h023, 0, 32'hFFFFFFEF, 0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h020, 0, 32'h00000080, 0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h020, 0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, SZ_WORD, 1, 32'h020, 0, 32'h80FFBEEF, 0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h022, 0, 32'hFFFFBEEF, 0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h012, 0, 32'h000033AA, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h012, 0, 32'h00000000, 1));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h3FF, 0, 32'h00000000, 0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h3FF, 32'h0000007F, 0, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h3FC, 0, 32'h0000007F, 0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'hFFFFFFFC, 0, 32'h00000000, 1));

    post.push_back(mk(0, SZ_WORD, 0, 32'h100, 0, 32'h00000000, 0));
    post.push_back(mk(0, SZ_WORD, 0, 32'h3FC, 0, 32'h00000000, 0));
    post.push_back(mk(0, SZ_WORD, 0, 32'h010, 0, 32'h00000000, 0));

    rst = 1'b1;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check32("reset a.ready", ifa.req_ready, 0);
    check32("reset a.valid", ifa.rsp_valid, 0);
    check32("reset a.rdata", ifa.rsp_rdata, 0);
    check32("reset a.error", ifa.rsp_error, 0);
    check32("reset b.ready", ifb.req_ready, 0);
    check32("reset b.valid", ifb.rsp_valid, 0);
    check32("reset b.rdata", ifb.rsp_rdata, 0);
    check32("reset b.error", ifb.rsp_error, 0);

    // Abort a sweep part-way; the restart must take the full length again.
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check32("midclear a.ready", ifa.req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("clear");

    foreach (vecs[i]) xact("vec", i, vecs[i]);

    // 8 back-to-back stores then 8 loads; the first load reads the word stored the edge before.
    pa = 0; pb = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 8)       drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h100 + 4 * i, pat(i));
      else if (i < 16) drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100 + 4 * (15 - i), 32'd0);
      else             drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      chk_stream("a", i, 0, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_error, pa);
      chk_stream("b", i, 2, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_error, pb);
    end
    check32("stream a.pulses", pa, 16);
    check32("stream b.pulses", pb, 16);

    // Two loads in flight in B when reset hits: neither may surface.
    nb = 0;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0);
    @(posedge clk); #1;
    check32("flush a.rdata", ifa.rsp_rdata, pat(0));
    if (ifb.rsp_valid) nb++;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'd0);
    @(posedge clk); #1;
    if (ifb.rsp_valid) nb++;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ifb.rsp_valid) nb++;
    end
    check32("flush b.pulses", nb, 0);
    check32("flush a.ready", ifa.req_ready, 0);
    rst = 1'b0;
    wait_ready("reclear");

    foreach (post[i]) xact("post", i, post[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
